// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes one RV32 instruction per cycle, resolves operands through
// a priority-ordered bypass network and issues into a single ALU/MUL output register.
// Latency 1 cycle; stalls fetch on MUL RAW hazards and while the output register is blocked.
module decode_issue_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5,
  parameter int NUM_BYPASS     = 2,
  localparam int NUM_REGS      = 2 ** REGISTER_WIDTH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 valid_i,
  input  logic                                 flush_i,
  input  logic [ADDR_WIDTH-1:0]                pc_i,
  input  logic [31:0]                          instr_i,
  input  logic [DATA_WIDTH-1:0]                rs1_data_i,
  input  logic [DATA_WIDTH-1:0]                rs2_data_i,
  input  logic [NUM_BYPASS-1:0]                byp_valid_i,
  input  logic [NUM_BYPASS*REGISTER_WIDTH-1:0] byp_reg_i,
  input  logic [NUM_BYPASS*DATA_WIDTH-1:0]     byp_data_i,
  input  logic                                 mul_wb_i,
  input  logic [REGISTER_WIDTH-1:0]            mul_wb_reg_i,
  input  logic                                 alu_ready_i,
  input  logic                                 mul_ready_i,
  output logic                                 stall_o,
  output logic [REGISTER_WIDTH-1:0]            rs1_o,
  output logic [REGISTER_WIDTH-1:0]            rs2_o,
  output logic                                 alu_valid_o,
  output logic                                 mul_valid_o,
  output logic [ADDR_WIDTH-1:0]                pc_o,
  output logic [31:0]                          instr_o,
  output logic [REGISTER_WIDTH-1:0]            rd_o,
  output logic [DATA_WIDTH-1:0]                op1_o,
  output logic [DATA_WIDTH-1:0]                op2_o,
  output logic [DATA_WIDTH-1:0]                imm_o,
  output logic [NUM_REGS-1:0]                  sb_busy_o
);

  // RV32 major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Decode fields
  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [REGISTER_WIDTH-1:0] rs1_idx;
  logic [REGISTER_WIDTH-1:0] rs2_idx;
  logic [REGISTER_WIDTH-1:0] rd_idx;

  // Control
  logic is_mul;
  logic rs1_used;
  logic rs2_used;
  logic rs1_hazard;
  logic rs2_hazard;
  logic out_free;
  logic stall;
  logic accept;

  // Datapath
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] op1_res;
  logic [DATA_WIDTH-1:0] op2_res;

  // Registered state
  logic                      alu_valid_q, alu_valid_d;
  logic                      mul_valid_q, mul_valid_d;
  logic [ADDR_WIDTH-1:0]     pc_q,        pc_d;
  logic [31:0]               instr_q,     instr_d;
  logic [REGISTER_WIDTH-1:0] rd_q,        rd_d;
  logic [DATA_WIDTH-1:0]     op1_q,       op1_d;
  logic [DATA_WIDTH-1:0]     op2_q,       op2_d;
  logic [DATA_WIDTH-1:0]     imm_q,       imm_d;
  logic [NUM_REGS-1:0]       sb_q,        sb_d;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign rs1_idx = instr_i[19:15];
  assign rs2_idx = instr_i[24:20];
  assign rd_idx  = instr_i[11:7];

  // Instruction class and which source registers are actually read
  always_comb begin
    is_mul   = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0000001);
    rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  end

  // Immediate generation; B/J offsets have an implicit zero LSB
  always_comb begin
    imm32 = 32'd0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR:
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      OP_STORE:
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OP_BRANCH:
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      OP_JAL:
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {instr_i[31:12], 12'd0};
      default:
        imm32 = 32'd0;
    endcase
    imm_ext = DATA_WIDTH'($signed(imm32));
  end

  // Operand resolution: walk from the oldest source down so the youngest match wins
  always_comb begin
    op1_res = rs1_data_i;
    op2_res = rs2_data_i;
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      if (byp_valid_i[k] && (byp_reg_i[k*REGISTER_WIDTH +: REGISTER_WIDTH] == rs1_idx)) begin
        op1_res = byp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (byp_valid_i[k] && (byp_reg_i[k*REGISTER_WIDTH +: REGISTER_WIDTH] == rs2_idx)) begin
        op2_res = byp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (rs1_idx == '0) begin
      op1_res = '0;
    end
    if (rs2_idx == '0) begin
      op2_res = '0;
    end
  end

  // RAW hazard against pending MUL results; a same-cycle write-back releases the register
  always_comb begin
    rs1_hazard = rs1_used && (rs1_idx != '0) && sb_q[rs1_idx] &&
                 !(mul_wb_i && (mul_wb_reg_i == rs1_idx));
    rs2_hazard = rs2_used && (rs2_idx != '0) && sb_q[rs2_idx] &&
                 !(mul_wb_i && (mul_wb_reg_i == rs2_idx));
  end

  // Handshake: the output register can take a new op only once its current one is consumed
  always_comb begin
    out_free = (!alu_valid_q || alu_ready_i) && (!mul_valid_q || mul_ready_i);
    stall    = valid_i && !flush_i && (rs1_hazard || rs2_hazard || !out_free);
    accept   = valid_i && !flush_i && !stall;
  end

  // Issue register next-state: load on accept, drain when free, otherwise hold
  always_comb begin
    alu_valid_d = alu_valid_q;
    mul_valid_d = mul_valid_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    rd_d        = rd_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    imm_d       = imm_q;
    if (accept) begin
      alu_valid_d = !is_mul;
      mul_valid_d = is_mul;
      pc_d        = pc_i;
      instr_d     = instr_i;
      rd_d        = rd_idx;
      op1_d       = op1_res;
      op2_d       = op2_res;
      imm_d       = imm_ext;
    end else if (out_free) begin
      alu_valid_d = 1'b0;
      mul_valid_d = 1'b0;
    end
  end

  // Scoreboard next-state: clear on write-back first so a same-cycle set takes priority
  always_comb begin
    sb_d = sb_q;
    if (mul_wb_i) begin
      sb_d[mul_wb_reg_i] = 1'b0;
    end
    if (accept && is_mul && (rd_idx != '0)) begin
      sb_d[rd_idx] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_valid_q <= 1'b0;
      mul_valid_q <= 1'b0;
      pc_q        <= '0;
      instr_q     <= '0;
      rd_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      sb_q        <= '0;
    end else begin
      alu_valid_q <= alu_valid_d;
      mul_valid_q <= mul_valid_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      rd_q        <= rd_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      sb_q        <= sb_d;
    end
  end

  assign stall_o     = stall;
  assign rs1_o       = rs1_idx;
  assign rs2_o       = rs2_idx;
  assign alu_valid_o = alu_valid_q;
  assign mul_valid_o = mul_valid_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign rd_o        = rd_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign imm_o       = imm_q;
  assign sb_busy_o   = sb_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: decode, immediates, bypass priority,
// MUL scoreboard hazards, backpressure, flush and asynchronous reset.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_decode_issue_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int NB = 2;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           valid_i;
  logic           flush_i;
  logic [AW-1:0]  pc_i;
  logic [31:0]    instr_i;
  logic [DW-1:0]  rs1_data_i;
  logic [DW-1:0]  rs2_data_i;
  logic [NB-1:0]  byp_valid_i;
  logic [NB*RW-1:0] byp_reg_i;
  logic [NB*DW-1:0] byp_data_i;
  logic           mul_wb_i;
  logic [RW-1:0]  mul_wb_reg_i;
  logic           alu_ready_i;
  logic           mul_ready_i;
  logic           stall_o;
  logic [RW-1:0]  rs1_o;
  logic [RW-1:0]  rs2_o;
  logic           alu_valid_o;
  logic           mul_valid_o;
  logic [AW-1:0]  pc_o;
  logic [31:0]    instr_o;
  logic [RW-1:0]  rd_o;
  logic [DW-1:0]  op1_o;
  logic [DW-1:0]  op2_o;
  logic [DW-1:0]  imm_o;
  logic [31:0]    sb_busy_o;

  int total = 0;
  int bad   = 0;

  // Instruction encodings used by the scenarios
  localparam logic [31:0] I_ADDI_X1_M5 = {12'hFFB, 5'd0, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] I_MUL_X3     = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] I_ADD_X4_X3  = {7'b0000000, 5'd3, 5'd3, 3'b000, 5'd4, 7'b0110011};
  localparam logic [31:0] I_ADD_X6_X5  = {7'b0000000, 5'd5, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] I_LUI_X9     = {20'h12345, 5'd9, 7'b0110111};
  localparam logic [31:0] I_SW_M4      = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011};
  localparam logic [31:0] I_BEQ_M8     = {1'b1, 6'h3F, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'b1100011};
  localparam logic [31:0] I_JAL_2048   = {1'b0, 10'd0, 1'b1, 8'd0, 5'd1, 7'b1101111};
  localparam logic [31:0] I_MUL_X7     = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011};

  decode_issue_stage #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGISTER_WIDTH(RW), .NUM_BYPASS(NB)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .pc_i(pc_i), .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .byp_valid_i(byp_valid_i), .byp_reg_i(byp_reg_i), .byp_data_i(byp_data_i),
    .mul_wb_i(mul_wb_i), .mul_wb_reg_i(mul_wb_reg_i),
    .alu_ready_i(alu_ready_i), .mul_ready_i(mul_ready_i),
    .stall_o(stall_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .alu_valid_o(alu_valid_o), .mul_valid_o(mul_valid_o),
    .pc_o(pc_o), .instr_o(instr_o), .rd_o(rd_o),
    .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o), .sb_busy_o(sb_busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; flush_i = 1'b0; pc_i = '0; instr_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; byp_valid_i = '0; byp_reg_i = '0; byp_data_i = '0;
    mul_wb_i = 1'b0; mul_wb_reg_i = '0; alu_ready_i = 1'b1; mul_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b0;
    #12;
    total++; if (alu_valid_o !== 1'b0) begin bad++; $display("FAIL reset_alu_valid got=%b exp=0", alu_valid_o); end
    total++; if (mul_valid_o !== 1'b0) begin bad++; $display("FAIL reset_mul_valid got=%b exp=0", mul_valid_o); end
    total++; if (sb_busy_o !== 32'd0) begin bad++; $display("FAIL reset_sb got=%h exp=0", sb_busy_o); end
    total++; if ({pc_o, instr_o, op1_o, op2_o, imm_o} !== 160'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {pc_o, instr_o, op1_o, op2_o, imm_o}); end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    valid_i = 1'b1; pc_i = 32'h100; instr_i = I_ADDI_X1_M5; rs1_data_i = 32'h1234;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL addi_stall got=%b exp=0", stall_o); end
    total++; if (rs1_o !== 5'd0) begin bad++; $display("FAIL addi_rs1_addr got=%0d exp=0", rs1_o); end
    tick();
    valid_i = 1'b0;
    total++; if ({alu_valid_o, mul_valid_o} !== 2'b10) begin bad++; $display("FAIL addi_valids got=%b exp=10", {alu_valid_o, mul_valid_o}); end
    total++; if (imm_o !== 32'hFFFF_FFFB) begin bad++; $display("FAIL addi_imm got=%h exp=fffffffb", imm_o); end
    total++; if (op1_o !== 32'd0) begin bad++; $display("FAIL addi_op1_x0 got=%h exp=0", op1_o); end
    total++; if (rd_o !== 5'd1 || pc_o !== 32'h100) begin bad++; $display("FAIL addi_rd_pc got=%0d/%h exp=1/100", rd_o, pc_o); end
    tick();
    total++; if (alu_valid_o !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b exp=0", alu_valid_o); end
  endtask

  task automatic test_imm_types();
    valid_i = 1'b1; instr_i = I_SW_M4;
    tick();
    total++; if (imm_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_store got=%h exp=fffffffc", imm_o); end
    instr_i = I_BEQ_M8;
    tick();
    total++; if (imm_o !== 32'hFFFF_FFF8) begin bad++; $display("FAIL imm_branch got=%h exp=fffffff8", imm_o); end
    instr_i = I_JAL_2048;
    tick();
    total++; if (imm_o !== 32'h0000_0800) begin bad++; $display("FAIL imm_jal got=%h exp=00000800", imm_o); end
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_mul_hazard();
    valid_i = 1'b1; pc_i = 32'h200; instr_i = I_MUL_X3; rs1_data_i = 32'h11; rs2_data_i = 32'h22;
    tick();
    total++; if ({alu_valid_o, mul_valid_o} !== 2'b01) begin bad++; $display("FAIL mul_valids got=%b exp=01", {alu_valid_o, mul_valid_o}); end
    total++; if ({op1_o, op2_o} !== {32'h11, 32'h22}) begin bad++; $display("FAIL mul_ops got=%h exp=%h", {op1_o, op2_o}, {32'h11, 32'h22}); end
    total++; if (sb_busy_o !== 32'h0000_0008) begin bad++; $display("FAIL mul_sb_set got=%h exp=00000008", sb_busy_o); end
    pc_i = 32'h204; instr_i = I_ADD_X4_X3;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b exp=1", stall_o); end
    tick();
    total++; if ({alu_valid_o, mul_valid_o, stall_o} !== 3'b001) begin bad++; $display("FAIL raw_bubble got=%b exp=001", {alu_valid_o, mul_valid_o, stall_o}); end
    mul_wb_i = 1'b1; mul_wb_reg_i = 5'd3;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL raw_release got=%b exp=0", stall_o); end
    tick();
    mul_wb_i = 1'b0; valid_i = 1'b0;
    total++; if ({alu_valid_o, rd_o, pc_o} !== {1'b1, 5'd4, 32'h204}) begin bad++; $display("FAIL raw_issue got=%b/%0d/%h exp=1/4/204", alu_valid_o, rd_o, pc_o); end
    total++; if (sb_busy_o !== 32'd0) begin bad++; $display("FAIL mul_sb_clear got=%h exp=0", sb_busy_o); end
    tick();
  endtask

  task automatic test_bypass_priority();
    valid_i = 1'b1; instr_i = I_ADD_X6_X5; rs1_data_i = 32'hCC; rs2_data_i = 32'hDD;
    byp_valid_i = 2'b11; byp_reg_i = {5'd5, 5'd5}; byp_data_i = {32'hBB, 32'hAA};
    tick();
    total++; if ({op1_o, op2_o} !== {32'hAA, 32'hAA}) begin bad++; $display("FAIL byp_both got=%h exp=%h", {op1_o, op2_o}, {32'hAA, 32'hAA}); end
    byp_valid_i = 2'b10;
    tick();
    total++; if (op1_o !== 32'hBB) begin bad++; $display("FAIL byp_older got=%h exp=bb", op1_o); end
    byp_reg_i = {5'd8, 5'd5};
    tick();
    total++; if ({op1_o, op2_o} !== {32'hCC, 32'hDD}) begin bad++; $display("FAIL byp_miss got=%h exp=%h", {op1_o, op2_o}, {32'hCC, 32'hDD}); end
    valid_i = 1'b0; byp_valid_i = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    alu_ready_i = 1'b0; valid_i = 1'b1; pc_i = 32'h300; instr_i = I_ADDI_X1_M5;
    tick();
    total++; if (alu_valid_o !== 1'b1) begin bad++; $display("FAIL bp_first got=%b exp=1", alu_valid_o); end
    pc_i = 32'h304; instr_i = I_LUI_X9;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL bp_stall got=%b exp=1", stall_o); end
    tick();
    total++; if ({alu_valid_o, instr_o, pc_o} !== {1'b1, I_ADDI_X1_M5, 32'h300}) begin bad++; $display("FAIL bp_hold got=%b/%h/%h exp=1/%h/300", alu_valid_o, instr_o, pc_o, I_ADDI_X1_M5); end
    alu_ready_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL bp_unstall got=%b exp=0", stall_o); end
    tick();
    valid_i = 1'b0;
    total++; if ({instr_o, imm_o, rd_o} !== {I_LUI_X9, 32'h1234_5000, 5'd9}) begin bad++; $display("FAIL bp_accept got=%h/%h/%0d exp=%h/12345000/9", instr_o, imm_o, rd_o, I_LUI_X9); end
  endtask

  task automatic test_flush();
    alu_ready_i = 1'b0; valid_i = 1'b1; flush_i = 1'b1; instr_i = I_ADD_X6_X5;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    tick();
    total++; if ({alu_valid_o, instr_o} !== {1'b1, I_LUI_X9}) begin bad++; $display("FAIL flush_hold got=%b/%h exp=1/%h", alu_valid_o, instr_o, I_LUI_X9); end
    alu_ready_i = 1'b1;
    tick();
    total++; if ({alu_valid_o, mul_valid_o, instr_o} !== {2'b00, I_LUI_X9}) begin bad++; $display("FAIL flush_no_issue got=%b/%h exp=00/%h", {alu_valid_o, mul_valid_o}, instr_o, I_LUI_X9); end
    valid_i = 1'b0; flush_i = 1'b0;
    tick();
  endtask

  task automatic test_sb_set_wins_reset();
    valid_i = 1'b1; instr_i = I_MUL_X7; mul_wb_i = 1'b1; mul_wb_reg_i = 5'd7;
    tick();
    valid_i = 1'b0; mul_wb_i = 1'b0;
    total++; if ({mul_valid_o, sb_busy_o} !== {1'b1, 32'h0000_0080}) begin bad++; $display("FAIL sb_set_wins got=%b/%h exp=1/00000080", mul_valid_o, sb_busy_o); end
    #2;
    rst_i = 1'b0;
    #1;
    total++; if ({mul_valid_o, sb_busy_o} !== 33'd0) begin bad++; $display("FAIL async_reset got=%b/%h exp=0/0", mul_valid_o, sb_busy_o); end
    tick();
    mul_wb_i = 1'b1; mul_wb_reg_i = 5'd7;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    mul_wb_i = 1'b0;
    total++; if (sb_busy_o !== 32'd0) begin bad++; $display("FAIL wb_after_reset got=%h exp=0", sb_busy_o); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_imm_types();
    test_mul_hazard();
    test_bypass_priority();
    test_backpressure();
    test_flush();
    test_sb_set_wins_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
